// File: rtl/cr_huf_comp_sc_long_xmit.sv
// Scans the long-symbol histogram and streams nonzero (sym,cnt) entries to the insertion sort, eob on the last.
// Optional CR_HUF_COMP_SC_LONG_CLR_EN: zero each histogram entry as it is read.
module cr_huf_comp_sc_long_xmit #(
  parameter int DAT_WIDTH   = 6,
  parameter int CNT_WIDTH   = 10,
  parameter int NUM_SYM     = 64,
  parameter int SEQID_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SEQID_WIDTH-1:0] start_seq_id,
  output logic                   busy,
  output logic                   ram_rd_en,
  output logic [DAT_WIDTH-1:0]   ram_addr,
  input  logic [CNT_WIDTH-1:0]   ram_rd_dat,
  output logic                   ram_wr_en,
  output logic [CNT_WIDTH-1:0]   ram_wr_dat,
  output logic                   sc_is_long_vld,
  output logic [DAT_WIDTH-1:0]   sc_is_long_sym,
  output logic [CNT_WIDTH-1:0]   sc_is_long_cnt,
  output logic [SEQID_WIDTH-1:0] sc_is_long_seq_id,
  output logic                   sc_is_long_eob,
  input  logic                   is_sc_long_rd
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CHK  = 3'd2;
  localparam logic [2:0] ST_PUSH = 3'd3;
  localparam logic [2:0] ST_LAST = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;

  localparam logic [DAT_WIDTH-1:0] LAST_ADDR = DAT_WIDTH'(NUM_SYM - 1);

  logic [2:0]             state_q,    state_d;
  logic [DAT_WIDTH-1:0]   addr_q,     addr_d;
  logic [SEQID_WIDTH-1:0] seq_q,      seq_d;
  logic                   busy_q,     busy_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [DAT_WIDTH-1:0]   pend_sym_q, pend_sym_d;
  logic [CNT_WIDTH-1:0]   pend_cnt_q, pend_cnt_d;
  logic                   cap_vld_q,  cap_vld_d;
  logic [DAT_WIDTH-1:0]   cap_sym_q,  cap_sym_d;
  logic [CNT_WIDTH-1:0]   cap_cnt_q,  cap_cnt_d;
  logic                   out_vld_q,  out_vld_d;
  logic [DAT_WIDTH-1:0]   out_sym_q,  out_sym_d;
  logic [CNT_WIDTH-1:0]   out_cnt_q,  out_cnt_d;
  logic [SEQID_WIDTH-1:0] out_seq_q,  out_seq_d;
  logic                   out_eob_q,  out_eob_d;
  logic                   out_free;
  logic                   advance;

  assign out_free = !out_vld_q || is_sc_long_rd;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    seq_d      = seq_q;
    busy_d     = busy_q;
    pend_vld_d = pend_vld_q;
    pend_sym_d = pend_sym_q;
    pend_cnt_d = pend_cnt_q;
    cap_vld_d  = cap_vld_q;
    cap_sym_d  = cap_sym_q;
    cap_cnt_d  = cap_cnt_q;
    out_vld_d  = out_vld_q;
    out_sym_d  = out_sym_q;
    out_cnt_d  = out_cnt_q;
    out_seq_d  = out_seq_q;
    out_eob_d  = out_eob_q;
    advance    = 1'b0;

    if (out_vld_q && is_sc_long_rd) out_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seq_d   = start_seq_id;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: state_d = ST_CHK;
      ST_CHK: begin
        advance = 1'b1;
        if (ram_rd_dat != '0) begin
          if (!pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_sym_d = addr_q;
            pend_cnt_d = ram_rd_dat;
          end else begin
            cap_vld_d = 1'b1;
            cap_sym_d = addr_q;
            cap_cnt_d = ram_rd_dat;
            advance   = 1'b0;
            state_d   = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        if (out_free) begin
          out_vld_d  = 1'b1;
          out_sym_d  = pend_sym_q;
          out_cnt_d  = pend_cnt_q;
          out_seq_d  = seq_q;
          out_eob_d  = 1'b0;
          pend_sym_d = cap_sym_q;
          pend_cnt_d = cap_cnt_q;
          cap_vld_d  = 1'b0;
          advance    = 1'b1;
        end
      end
      ST_LAST: begin
        // An all-zero block still emits one eob beat (sym 0, cnt 0) so the sorter can close it.
        if (out_free) begin
          out_vld_d  = 1'b1;
          out_sym_d  = pend_vld_q ? pend_sym_q : '0;
          out_cnt_d  = pend_vld_q ? pend_cnt_q : '0;
          out_seq_d  = seq_q;
          out_eob_d  = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (out_vld_q && is_sc_long_rd) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        state_d = ST_LAST;
      end else begin
        addr_d  = addr_q + DAT_WIDTH'(1);
        state_d = ST_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      seq_q      <= '0;
      busy_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_sym_q <= '0;
      pend_cnt_q <= '0;
      cap_vld_q  <= 1'b0;
      cap_sym_q  <= '0;
      cap_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_sym_q  <= '0;
      out_cnt_q  <= '0;
      out_seq_q  <= '0;
      out_eob_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      seq_q      <= seq_d;
      busy_q     <= busy_d;
      pend_vld_q <= pend_vld_d;
      pend_sym_q <= pend_sym_d;
      pend_cnt_q <= pend_cnt_d;
      cap_vld_q  <= cap_vld_d;
      cap_sym_q  <= cap_sym_d;
      cap_cnt_q  <= cap_cnt_d;
      out_vld_q  <= out_vld_d;
      out_sym_q  <= out_sym_d;
      out_cnt_q  <= out_cnt_d;
      out_seq_q  <= out_seq_d;
      out_eob_q  <= out_eob_d;
    end
  end

  assign busy              = busy_q;
  assign ram_rd_en         = (state_q == ST_RD);
  assign ram_addr          = addr_q;
  assign ram_wr_dat        = '0;
  assign sc_is_long_vld    = out_vld_q;
  assign sc_is_long_sym    = out_sym_q;
  assign sc_is_long_cnt    = out_cnt_q;
  assign sc_is_long_seq_id = out_seq_q;
  assign sc_is_long_eob    = out_eob_q;

`ifdef CR_HUF_COMP_SC_LONG_CLR_EN
  assign ram_wr_en = (state_q == ST_CHK);
`else
  assign ram_wr_en = 1'b0;
`endif

endmodule

// File: tb/tb_cr_huf_comp_sc_long_xmit.sv
// Directed bench for cr_huf_comp_sc_long_xmit: histogram RAM model plus a consumer with optional 5-cycle stall.
module tb_cr_huf_comp_sc_long_xmit;

  typedef struct packed {
    logic [5:0] sym;
    logic [9:0] cnt;
    logic [3:0] seq;
    logic       eob;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] start_seq_id;
  logic       busy;
  logic       ram_rd_en;
  logic [5:0] ram_addr;
  logic [9:0] ram_rd_dat;
  logic       ram_wr_en;
  logic [9:0] ram_wr_dat;
  logic       sc_is_long_vld;
  logic [5:0] sc_is_long_sym;
  logic [9:0] sc_is_long_cnt;
  logic [3:0] sc_is_long_seq_id;
  logic       sc_is_long_eob;
  logic       is_sc_long_rd;

  int    n_vec = 0;
  int    n_err = 0;
  logic [9:0] mem [64];
  int    wr_cnt [64];
  int    wr_bad = 0;
  int    stab_err = 0;
  bit    stall_mode = 0;
  int    wait_cnt = 0;
  bit    held_vld = 0;
  beat_t held;
  beat_t beats [$];
  time   eob_acc_t = 0;
  time   done_t = 0;

  always #5 clk = ~clk;

  cr_huf_comp_sc_long_xmit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .start_seq_id      (start_seq_id),
    .busy              (busy),
    .ram_rd_en         (ram_rd_en),
    .ram_addr          (ram_addr),
    .ram_rd_dat        (ram_rd_dat),
    .ram_wr_en         (ram_wr_en),
    .ram_wr_dat        (ram_wr_dat),
    .sc_is_long_vld    (sc_is_long_vld),
    .sc_is_long_sym    (sc_is_long_sym),
    .sc_is_long_cnt    (sc_is_long_cnt),
    .sc_is_long_seq_id (sc_is_long_seq_id),
    .sc_is_long_eob    (sc_is_long_eob),
    .is_sc_long_rd     (is_sc_long_rd)
  );

  // Histogram RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_dat <= mem[ram_addr];
  end

  // Consumer, stability monitor and RAM write capture.
  always @(negedge clk) begin
    beat_t cur;
    cur = '{sym: sc_is_long_sym, cnt: sc_is_long_cnt, seq: sc_is_long_seq_id, eob: sc_is_long_eob};
    if (!rst_n) begin
      held_vld = 0;
      wait_cnt = 0;
      is_sc_long_rd = 1'b0;
    end else begin
      if (held_vld && (!sc_is_long_vld || cur !== held)) stab_err++;
      if (ram_wr_en) begin
        wr_cnt[ram_addr]++;
        if (ram_wr_dat !== 10'd0) wr_bad++;
        mem[ram_addr] = 10'd0;
      end
      if (sc_is_long_vld) begin
        if (!stall_mode || wait_cnt == 5) begin
          is_sc_long_rd = 1'b1;
          beats.push_back(cur);
          if (sc_is_long_eob) eob_acc_t = $time;
          wait_cnt = 0;
          held_vld = 0;
        end else begin
          is_sc_long_rd = 1'b0;
          wait_cnt++;
          held_vld = 1;
          held = cur;
        end
      end else begin
        is_sc_long_rd = !stall_mode;
        held_vld = 0;
        wait_cnt = 0;
      end
    end
  end

  task automatic load_mem(input bit three);
    for (int i = 0; i < 64; i++) mem[i] = 10'd0;
    if (three) begin
      mem[0]  = 10'd1;
      mem[10] = 10'd200;
      mem[63] = 10'd1023;
    end
  endtask

  task automatic do_block(input logic [3:0] sid, input int mid_at);
    bit done;
    done = 0;
    beats.delete();
    @(negedge clk);
    start = 1'b1;
    start_seq_id = sid;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (i == mid_at) begin
        start = 1'b1;
        start_seq_id = 4'hF;
      end else begin
        start = 1'b0;
        start_seq_id = 4'h0;
      end
      if (i > 0 && !busy && !start) begin
        done = 1;
        done_t = $time;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL block_timeout seq=%0d busy=%b required busy=0", sid, busy);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({sc_is_long_vld, sc_is_long_eob, busy, ram_rd_en, ram_wr_en} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b required=00000",
               {sc_is_long_vld, sc_is_long_eob, busy, ram_rd_en, ram_wr_en});
    end
    n_vec++;
    if ({sc_is_long_sym, sc_is_long_cnt, sc_is_long_seq_id, ram_addr, ram_wr_dat} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_data got sym=%0d cnt=%0d seq=%0d addr=%0d wdat=%0d required all 0",
               sc_is_long_sym, sc_is_long_cnt, sc_is_long_seq_id, ram_addr, ram_wr_dat);
    end
  endtask

  task automatic test_empty();
    beat_t exp;
    load_mem(0);
    stall_mode = 0;
    do_block(4'd3, -1);
    exp = '{sym: 6'd0, cnt: 10'd0, seq: 4'd3, eob: 1'b1};
    n_vec++;
    if (beats.size() !== 1) begin
      n_err++;
      $display("FAIL empty_count got=%0d required=1", beats.size());
    end else begin
      n_vec++;
      if (beats[0] !== exp) begin
        n_err++;
        $display("FAIL empty_beat got=%h required=%h", beats[0], exp);
      end
    end
    n_vec++;
    if (done_t !== eob_acc_t + 10) begin
      n_err++;
      $display("FAIL empty_busy_drop got=%0t required=%0t", done_t, eob_acc_t + 10);
    end
  endtask

  task automatic test_single();
    beat_t exp;
    load_mem(0);
    mem[5] = 10'd7;
    stall_mode = 0;
    do_block(4'd9, -1);
    exp = '{sym: 6'd5, cnt: 10'd7, seq: 4'd9, eob: 1'b1};
    n_vec++;
    if (beats.size() !== 1) begin
      n_err++;
      $display("FAIL single_count got=%0d required=1", beats.size());
    end else begin
      n_vec++;
      if (beats[0] !== exp) begin
        n_err++;
        $display("FAIL single_beat got=%h required=%h", beats[0], exp);
      end
    end
  endtask

  task automatic test_three(input string name, input bit stall, input logic [3:0] sid, input int mid_at);
    beat_t exp [3];
    load_mem(1);
    stall_mode = stall;
    stab_err = 0;
    do_block(sid, mid_at);
    exp[0] = '{sym: 6'd0,  cnt: 10'd1,    seq: sid, eob: 1'b0};
    exp[1] = '{sym: 6'd10, cnt: 10'd200,  seq: sid, eob: 1'b0};
    exp[2] = '{sym: 6'd63, cnt: 10'd1023, seq: sid, eob: 1'b1};
    n_vec++;
    if (beats.size() !== 3) begin
      n_err++;
      $display("FAIL %s_count got=%0d required=3", name, beats.size());
    end
    for (int i = 0; i < 3 && i < beats.size(); i++) begin
      n_vec++;
      if (beats[i] !== exp[i]) begin
        n_err++;
        $display("FAIL %s_beat%0d got=%h required=%h", name, i, beats[i], exp[i]);
      end
    end
    n_vec++;
    if (stab_err !== 0) begin
      n_err++;
      $display("FAIL %s_stable got=%0d unstable cycles required=0", name, stab_err);
    end
    stall_mode = 0;
  endtask

  task automatic test_reset_mid();
    load_mem(1);
    stall_mode = 0;
    beats.delete();
    @(negedge clk);
    start = 1'b1;
    start_seq_id = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({sc_is_long_vld, sc_is_long_eob, busy, ram_rd_en, sc_is_long_sym, sc_is_long_cnt,
         sc_is_long_seq_id, ram_addr} !== 36'd0) begin
      n_err++;
      $display("FAIL midreset_outputs got vld=%b busy=%b addr=%0d sym=%0d required all 0",
               sc_is_long_vld, busy, ram_addr, sc_is_long_sym);
    end
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    n_vec++;
    if (beats.size() !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_abort got beats=%0d busy=%b required beats=0 busy=0", beats.size(), busy);
    end
    test_three("post_reset", 0, 4'd2, -1);
  endtask

  task automatic test_write();
`ifdef CR_HUF_COMP_SC_LONG_CLR_EN
    beat_t exp;
    for (int i = 0; i < 64; i++) wr_cnt[i] = 0;
    wr_bad = 0;
    load_mem(1);
    do_block(4'd4, -1);
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (wr_cnt[i] !== 1) begin
        n_err++;
        $display("FAIL clr_wr_addr%0d got=%0d writes required=1", i, wr_cnt[i]);
      end
    end
    n_vec++;
    if (wr_bad !== 0) begin
      n_err++;
      $display("FAIL clr_wr_data got=%0d nonzero writes required=0", wr_bad);
    end
    do_block(4'd5, -1);
    exp = '{sym: 6'd0, cnt: 10'd0, seq: 4'd5, eob: 1'b1};
    n_vec++;
    if (beats.size() !== 1 || beats[0] !== exp) begin
      n_err++;
      $display("FAIL clr_second_block got count=%0d first=%h required count=1 first=%h",
               beats.size(), (beats.size() > 0) ? beats[0] : '0, exp);
    end
`else
    n_vec++;
    if (wr_bad !== 0) begin
      n_err++;
      $display("FAIL no_write got=%0d writes required=0", wr_bad);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_seq_id = 4'd0;
    is_sc_long_rd = 1'b0;
    load_mem(0);
    for (int i = 0; i < 64; i++) wr_cnt[i] = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_empty();
    test_single();
    test_three("rd_high", 0, 4'd12, -1);
    test_three("stall", 1, 4'd6, -1);
    test_three("start_ignored", 0, 4'd1, 20);
    test_reset_mid();
    test_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr_huf_comp_sc_long_xmit.md
Name: cr_huf_comp_sc_long_xmit

Overview:
- Producer end of the symbol-counter to insertion-sort long-symbol interface.
- On `start`, scans the long-symbol histogram RAM and sends each nonzero (symbol, count) entry to the insertion sort, in ascending symbol order, over a vld/rd handshake.
- Tags the final entry of the block with eob and the block's seq_id.
- Sits in cr_huf_comp between the long histogram RAM and the long insertion-sort instance.

Parameters:
- DAT_WIDTH, 6, symbol index width.
- CNT_WIDTH, 10, histogram count width.
- NUM_SYM, 64, number of histogram entries scanned; NUM_SYM <= 2**DAT_WIDTH.
- SEQID_WIDTH, 4, sequence id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begin scan of a block; honoured only when busy=0
- start_seq_id  in  SEQID_WIDTH  seq id of the block; sampled with start
- busy  out  1  high from start until the eob beat is accepted
- ram_rd_en  out  1  histogram read strobe
- ram_addr  out  DAT_WIDTH  histogram address (read and write)
- ram_rd_dat  in  CNT_WIDTH  read data, valid exactly 1 cycle after ram_rd_en
- ram_wr_en  out  1  histogram write strobe (clear feature only; otherwise tied 0)
- ram_wr_dat  out  CNT_WIDTH  write data, always 0
- sc_is_long_vld  out  1  output entry valid
- sc_is_long_sym  out  DAT_WIDTH  symbol index
- sc_is_long_cnt  out  CNT_WIDTH  symbol count
- sc_is_long_seq_id  out  SEQID_WIDTH  block seq id
- sc_is_long_eob  out  1  last entry of block
- is_sc_long_rd  in  1  consumer accepts the current entry

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low (rst_n).
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - pend/cap buffers invalid;
  - addr 0.
- Reset asserted mid-scan aborts the block immediately; no eob is sent.
- Output register handshake:
  - Once vld=1, sym/cnt/seq_id/eob are held stable until a cycle with is_sc_long_rd=1.
  - vld clears at that edge unless the register reloads on the same edge. The output register is "free" when !vld || is_sc_long_rd.
  - is_sc_long_rd with vld=0 is ignored.
- Internal buffers:
  - pend: one held entry, so eob can be attached to the last nonzero entry.
  - cap: one capture register.
- FSM:
  - IDLE: on start, latch seq_id, addr<=0, busy<=1, go to RD.
  - RD: ram_rd_en=1, ram_addr=addr; go to CHK.
  - CHK: ram_rd_dat is valid.
    - If nonzero and pend is empty: pend<=(addr,dat).
    - If nonzero and pend is full: cap<=(addr,dat) and go to PUSH.
    - If zero: nothing is stored.
    - Next state (when not going to PUSH): addr==NUM_SYM-1 goes to LAST; otherwise addr++ and go to RD.
  - PUSH: wait until the output register is free. Then out<=pend with eob=0, pend<=cap, and take the same next-state decision as CHK.
  - LAST: wait until the output register is free.
    - If pend is valid: out<=pend with eob=1.
    - Otherwise: out<=(sym 0, cnt 0, eob 1), an empty-block marker.
    - Go to WAIT.
  - WAIT: when the eob beat is accepted, busy<=0 and go to IDLE. A new start is honoured from the following cycle.
- Throughput: 2 cycles per histogram entry plus backpressure. Minimum start-to-first-vld latency is 2 cycles after the second nonzero entry's CHK, or after LAST.
- A start pulse while busy=1 is ignored.
- sc_is_long_seq_id equals the latched seq id on every beat of the block.
- Counts pass through unmodified; there is no saturation.

Optional Feature:
- Macro: CR_HUF_COMP_SC_LONG_CLR_EN.
- Defined: in every CHK cycle, ram_wr_en=1 with ram_addr=addr and ram_wr_dat=0, so the histogram is zeroed for the next block.
- Undefined: ram_wr_en is constant 0 and the histogram RAM is read-only to this block.

Test Plan:
- All-zero histogram, start with seq_id 3 -> exactly one beat (sym 0, cnt 0, seq_id 3, eob 1); busy drops the cycle after rd.
- Only sym 5 = 7 -> one beat (5, 7, eob 1); no other vld.
- Nonzero sym 0=1, sym 10=200, sym 63=1023 with rd tied high -> three beats in that order; eob=1 only on sym 63.
- Same histogram with rd asserted 5 cycles after each vld -> outputs stable while stalled; no beat lost or duplicated.
- start pulsed again mid-scan -> ignored. rst_n low for 1 cycle mid-scan -> all outputs 0; the next start yields a full, correct block.
- With CR_HUF_COMP_SC_LONG_CLR_EN defined -> one ram_wr_en per address 0..63 with data 0; a second block on the same RAM yields only the empty-block eob beat.
